// File: rtl/recur_mem_if.sv
// Bus bundle between write_back, the pipeline scheduler port and the
// state / InexRecur RAM write ports of the recursion memory controller.
interface recur_mem_if #(
    parameter int ADDR_W  = 12,
    parameter int STATE_W = 18,
    parameter int REC_W   = 32
);
    logic               start;
    logic               seq_we_state;
    logic [STATE_W-1:0] seq_w_data_state;
    logic               seq_we_InexRecur;
    logic [REC_W-1:0]   seq_w_data_InexRecur;
    logic               ran_we_state;
    logic [STATE_W-1:0] ran_w_data_state;
    logic [ADDR_W-1:0]  ran_w_addr_state;
    logic               state_we;
    logic [ADDR_W-1:0]  state_waddr;
    logic [STATE_W-1:0] state_wdata;
    logic               rec_we;
    logic [ADDR_W-1:0]  rec_waddr;
    logic [REC_W-1:0]   rec_wdata;
    logic               nxt_req;
    logic               nxt_vld;
    logic [ADDR_W-1:0]  nxt_addr;
    logic               all_done;
    logic               stall;
    logic [ADDR_W:0]    count;
    logic               full;
    logic               err_ovf;
    logic               err_pair;

    modport master (
        output start, seq_we_state, seq_w_data_state,
        output seq_we_InexRecur, seq_w_data_InexRecur,
        output ran_we_state, ran_w_data_state, ran_w_addr_state,
        output nxt_req,
        input  state_we, state_waddr, state_wdata,
        input  rec_we, rec_waddr, rec_wdata,
        input  nxt_vld, nxt_addr, all_done, stall,
        input  count, full, err_ovf, err_pair
    );

    modport slave (
        input  start, seq_we_state, seq_w_data_state,
        input  seq_we_InexRecur, seq_w_data_InexRecur,
        input  ran_we_state, ran_w_data_state, ran_w_addr_state,
        input  nxt_req,
        output state_we, state_waddr, state_wdata,
        output rec_we, rec_waddr, rec_wdata,
        output nxt_vld, nxt_addr, all_done, stall,
        output count, full, err_ovf, err_pair
    );
endinterface

// File: rtl/recur_mem_ctrl.sv
// Allocates new calls into the state / InexRecur RAMs, arbitrates the
// state write port with a 1-entry skid buffer, dispatches calls in order.
module recur_mem_ctrl #(
    parameter int ADDR_W  = 12,
    parameter int DEPTH   = 4096,
    parameter int STATE_W = 18,
    parameter int REC_W   = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    recur_mem_if.slave bus
);
    localparam logic [ADDR_W:0] FULL_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C  = (ADDR_W+1)'(1);

    logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]    dp_q, dp_d;
    logic               buf_vld_q, buf_vld_d;
    logic [ADDR_W-1:0]  buf_addr_q, buf_addr_d;
    logic [STATE_W-1:0] buf_data_q, buf_data_d;
    logic               state_we_q, state_we_d;
    logic [ADDR_W-1:0]  state_waddr_q, state_waddr_d;
    logic [STATE_W-1:0] state_wdata_q, state_wdata_d;
    logic               rec_we_q, rec_we_d;
    logic [ADDR_W-1:0]  rec_waddr_q, rec_waddr_d;
    logic [REC_W-1:0]   rec_wdata_q, rec_wdata_d;
    logic               nxt_vld_q, nxt_vld_d;
    logic [ADDR_W-1:0]  nxt_addr_q, nxt_addr_d;
    logic               err_ovf_q, err_ovf_d;
    logic               err_pair_q, err_pair_d;

    logic full_w, accept_w, reject_w, seq_st_w, ran_w, issue_w;

    // Request qualification; start masks every request in its cycle.
    always_comb begin
        full_w   = (wr_ptr_q == FULL_C);
        accept_w = !bus.start && bus.seq_we_InexRecur
                   && !full_w && !buf_vld_q;
        reject_w = !bus.start && bus.seq_we_InexRecur
                   && (full_w || buf_vld_q);
        seq_st_w = accept_w && bus.seq_we_state;
        ran_w    = !bus.start && bus.ran_we_state;
        issue_w  = !bus.start && bus.nxt_req && (dp_q < wr_ptr_q);
    end

    // Next-state: allocation, state-port arbitration, dispatch, errors.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        dp_d          = dp_q;
        buf_vld_d     = buf_vld_q;
        buf_addr_d    = buf_addr_q;
        buf_data_d    = buf_data_q;
        state_we_d    = 1'b0;
        state_waddr_d = state_waddr_q;
        state_wdata_d = state_wdata_q;
        rec_we_d      = 1'b0;
        rec_waddr_d   = rec_waddr_q;
        rec_wdata_d   = rec_wdata_q;
        nxt_vld_d     = 1'b0;
        nxt_addr_d    = nxt_addr_q;
        err_ovf_d     = err_ovf_q | reject_w;
        err_pair_d    = err_pair_q
                        | (bus.seq_we_state != bus.seq_we_InexRecur);
        if (bus.start) begin
            wr_ptr_d   = '0;
            dp_d       = '0;
            buf_vld_d  = 1'b0;
            err_ovf_d  = 1'b0;
            err_pair_d = 1'b0;
        end else begin
            if (accept_w) begin
                rec_we_d    = 1'b1;
                rec_waddr_d = wr_ptr_q[ADDR_W-1:0];
                rec_wdata_d = bus.seq_w_data_InexRecur;
                wr_ptr_d    = wr_ptr_q + ONE_C;
            end
            // Random writes always win; a colliding new-call word parks.
            if (ran_w) begin
                state_we_d    = 1'b1;
                state_waddr_d = bus.ran_w_addr_state;
                state_wdata_d = bus.ran_w_data_state;
                if (seq_st_w) begin
                    buf_vld_d  = 1'b1;
                    buf_addr_d = wr_ptr_q[ADDR_W-1:0];
                    buf_data_d = bus.seq_w_data_state;
                end
            end else if (buf_vld_q) begin
                state_we_d    = 1'b1;
                state_waddr_d = buf_addr_q;
                state_wdata_d = buf_data_q;
                buf_vld_d     = 1'b0;
            end else if (seq_st_w) begin
                state_we_d    = 1'b1;
                state_waddr_d = wr_ptr_q[ADDR_W-1:0];
                state_wdata_d = bus.seq_w_data_state;
            end
            if (issue_w) begin
                nxt_vld_d  = 1'b1;
                nxt_addr_d = dp_q[ADDR_W-1:0];
                dp_d       = dp_q + ONE_C;
            end
        end
    end

    // State registers; reset drops any parked state word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            dp_q          <= '0;
            buf_vld_q     <= 1'b0;
            buf_addr_q    <= '0;
            buf_data_q    <= '0;
            state_we_q    <= 1'b0;
            state_waddr_q <= '0;
            state_wdata_q <= '0;
            rec_we_q      <= 1'b0;
            rec_waddr_q   <= '0;
            rec_wdata_q   <= '0;
            nxt_vld_q     <= 1'b0;
            nxt_addr_q    <= '0;
            err_ovf_q     <= 1'b0;
            err_pair_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            dp_q          <= dp_d;
            buf_vld_q     <= buf_vld_d;
            buf_addr_q    <= buf_addr_d;
            buf_data_q    <= buf_data_d;
            state_we_q    <= state_we_d;
            state_waddr_q <= state_waddr_d;
            state_wdata_q <= state_wdata_d;
            rec_we_q      <= rec_we_d;
            rec_waddr_q   <= rec_waddr_d;
            rec_wdata_q   <= rec_wdata_d;
            nxt_vld_q     <= nxt_vld_d;
            nxt_addr_q    <= nxt_addr_d;
            err_ovf_q     <= err_ovf_d;
            err_pair_q    <= err_pair_d;
        end
    end

    assign bus.state_we    = state_we_q;
    assign bus.state_waddr = state_waddr_q;
    assign bus.state_wdata = state_wdata_q;
    assign bus.rec_we      = rec_we_q;
    assign bus.rec_waddr   = rec_waddr_q;
    assign bus.rec_wdata   = rec_wdata_q;
    assign bus.nxt_vld     = nxt_vld_q;
    assign bus.nxt_addr    = nxt_addr_q;
    assign bus.stall       = buf_vld_q;
    assign bus.count       = wr_ptr_q;
    assign bus.full        = full_w;
    assign bus.err_ovf     = err_ovf_q;
    assign bus.err_pair    = err_pair_q;
    assign bus.all_done    = (dp_q == wr_ptr_q) && !buf_vld_q
                             && (wr_ptr_q != '0);
endmodule
